// File: rtl/mem_access_unit.sv
// Load/store unit: takes one MIPS load/store at a time and turns it into
// word-wide reads and writes on the data-memory port. Sub-word stores are
// done as read-modify-write. Load data is extracted and extended here.
//
// state | meaning
// IDLE  | ready for a request
// RD    | mem_rd asserted, waiting for mem_ack
// WR    | mem_wr asserted, waiting for mem_ack
// DONE  | resp_valid pulse, back to IDLE next cycle
module mem_access_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    // Last counter value before giving up; unused when TIMEOUT is 0.
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [1:0]          lane_q, lane_d;
    logic [15:0]         wlo_q, wlo_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [1:0]          resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic        acc_legal, acc_half, acc_word;
    logic        tmo_hit;
    logic [31:0] rd_shift, load_val, merge_mask, merge_rep;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W+2];
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Classify the incoming opcode for the accept-time error checks.
    always_comb begin
        acc_legal = 1'b1;
        acc_half  = 1'b0;
        acc_word  = 1'b0;
        case (opcode)
            OP_LB, OP_LBU, OP_SB: ;
            OP_LH, OP_LHU, OP_SH: acc_half = 1'b1;
            OP_LW, OP_SW:         acc_word = 1'b1;
            default:              acc_legal = 1'b0;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        rd_shift   = mem_rdata >> {lane_q, 3'b000};
        load_val   = rd_shift;
        merge_mask = 32'h0000_00FF << {lane_q, 3'b000};
        merge_rep  = {4{wlo_q[7:0]}};
        case (op_q)
            OP_LB:   load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_val = {24'd0, rd_shift[7:0]};
            OP_LH:   load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            OP_LHU:  load_val = {16'd0, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
        if (op_q == OP_SH) begin
            merge_mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
            merge_rep  = {2{wlo_q}};
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        wlo_d       = wlo_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = opcode;
                    lane_d     = addr[1:0];
                    wlo_d      = wdata[15:0];
                    mem_addr_d = addr[ADDR_W+1:2];
                    cnt_d      = '0;
                    if (!acc_legal) begin
                        state_d     = DONE;
                        resp_err_d  = ERR_ILL;
                        resp_data_d = '0;
                    end else if ((acc_half && addr[0]) || (acc_word && addr[1:0] != 2'b00)) begin
                        state_d     = DONE;
                        resp_err_d  = ERR_MIS;
                        resp_data_d = '0;
                    end else if (opcode == OP_SW) begin
                        state_d     = WR;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    if (op_q == OP_SB || op_q == OP_SH) begin
                        mem_wdata_d = (mem_rdata & ~merge_mask) | (merge_rep & merge_mask);
                        cnt_d       = '0;
                        state_d     = WR;
                    end else begin
                        resp_data_d = load_val;
                        resp_err_d  = ERR_OK;
                        state_d     = DONE;
                    end
                end else if (tmo_hit) begin
                    resp_data_d = '0;
                    resp_err_d  = ERR_TMO;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WR: begin
                if (mem_ack) begin
                    resp_data_d = '0;
                    resp_err_d  = ERR_OK;
                    state_d     = DONE;
                end else if (tmo_hit) begin
                    resp_data_d = '0;
                    resp_err_d  = ERR_TMO;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        mem_rd_d     = (state_d == RD);
        mem_wr_d     = (state_d == WR);
    end

    // State and registered outputs; reset drops strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            lane_q       <= '0;
            wlo_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            wlo_q        <= wlo_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a memory responder with per-request ack delays,
// a request-level reference model, and a per-cycle compare process.
module tb_mem_access_unit;

    localparam int TO    = 16;
    localparam int NEVER = 99;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  opcode;
    logic [31:0] addr, wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    mem_access_unit #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          acc_cyc;
        int          resp_cyc;
        logic [31:0] data;
        logic [1:0]  err;
        int          n_rd;
        int          n_wr;
        int          idx;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          cur_rd_delay = 0, cur_wr_delay = 0;
    int          rd_idx = 0, wr_idx = 0;
    int          n_rd_cnt = 0, n_wr_cnt = 0;
    int          last_acc = 0, last_resp_cyc = 0, last_n_rd = 0, last_n_wr = 0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_err = '0;
    logic        exp_ready, exp_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, ncyc);
        end
    endtask

    // Reference: outcome of one request from the opcode rules and the chosen ack delays.
    function automatic exp_t model(logic [5:0] op, logic [31:0] a, logic [31:0] wd,
                                   int rdd, int wrd, int acc);
        exp_t e;
        int sz, off;
        bit ld, sgn;
        longint unsigned msk, val, nw;
        logic [31:0] word;
        e.acc_cyc = acc; e.idx = int'((a >> 2) & 32'hFF);
        e.data = '0; e.err = 2'd0; e.n_rd = 0; e.n_wr = 0;
        case (op)
            6'h20, 6'h24, 6'h28: sz = 1;
            6'h21, 6'h25, 6'h29: sz = 2;
            6'h23, 6'h2B:        sz = 4;
            default:             sz = 0;
        endcase
        off = int'(a & 32'h3);
        if (sz == 0) e.err = 2'd3;
        else if (off % sz != 0) e.err = 2'd1;
        if (e.err != 0) begin
            e.resp_cyc = acc + 1;
            return e;
        end
        ld  = (op < 6'h28);
        sgn = (op == 6'h20) || (op == 6'h21);
        msk = (64'd1 << (8 * sz)) - 64'd1;
        word = ref_mem[e.idx];
        if (ld || sz != 4) begin
            if (rdd >= TO) begin e.n_rd = TO; e.err = 2'd2; end
            else e.n_rd = rdd + 1;
        end
        if (e.err == 0 && ld) begin
            val = ({32'd0, word} >> (8 * off)) & msk;
            if (sgn && val > (msk >> 1)) val = val - (msk + 64'd1);
            e.data = 32'(val);
        end
        if (e.err == 0 && !ld) begin
            if (wrd >= TO) begin e.n_wr = TO; e.err = 2'd2; end
            else begin
                e.n_wr = wrd + 1;
                nw = ({32'd0, word} & ~(msk << (8 * off))) | (({32'd0, wd} & msk) << (8 * off));
                ref_mem[e.idx] = 32'(nw);
            end
        end
        e.resp_cyc = acc + 1 + e.n_rd + e.n_wr;
        return e;
    endfunction

    // Per-cycle compare against the model, then drive the memory side for the next edge.
    always @(negedge clk) begin
        ncyc++;
        chk("strobe_overlap", {31'd0, mem_rd & mem_wr}, 32'd0);
        exp_ready = !(q.size() != 0 && ncyc > q[0].acc_cyc);
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        if (q.size() != 0 && (mem_rd || mem_wr)) chk("mem_addr", {24'd0, mem_addr}, 32'(q[0].idx));
        if (mem_rd) n_rd_cnt++;
        if (mem_wr) n_wr_cnt++;
        exp_rv = (q.size() != 0) && (ncyc == q[0].resp_cyc);
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
        if (resp_valid) begin
            last_data = resp_data; last_err = resp_err; last_resp_cyc = ncyc;
            last_n_rd = n_rd_cnt; last_n_wr = n_wr_cnt;
        end
        if (exp_rv) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_err", {30'd0, resp_err}, {30'd0, q[0].err});
            chk("rd_cycles", 32'(n_rd_cnt), 32'(q[0].n_rd));
            chk("wr_cycles", 32'(n_wr_cnt), 32'(q[0].n_wr));
            chk("mem_word", mem[q[0].idx], ref_mem[q[0].idx]);
            void'(q.pop_front());
            n_rd_cnt = 0; n_wr_cnt = 0;
        end
        if (mem_rd && !mem_wr) begin
            mem_ack = (rd_idx == cur_rd_delay);
            mem_rdata = mem_ack ? mem[mem_addr] : $urandom;
            rd_idx++;
        end else if (mem_wr && !mem_rd) begin
            mem_ack = (wr_idx == cur_wr_delay);
            if (mem_ack) mem[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
            wr_idx++;
        end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
        if (!mem_rd) rd_idx = 0;
        if (!mem_wr) wr_idx = 0;
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int rdd, input int wrd);
        exp_t e;
        chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
        cur_rd_delay = rdd; cur_wr_delay = wrd;
        req_valid = 1'b1; opcode = op; addr = a; wdata = wd;
        last_acc = ncyc + 1;
        e = model(op, a, wd, rdd, wrd, last_acc);
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; opcode = 6'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            chk("resp_wait_expired", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int rdd, input int wrd);
        issue(op, a, wd, rdd, wrd);
        wait_resp();
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        mem[idx] = v; ref_mem[idx] = v;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ops[8];
        logic [5:0]  op;
        logic [31:0] a;
        int          rdd, wrd;
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        rst_n = 1'b0; req_valid = 1'b0; opcode = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) poke(i, $urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // lw 0x10, ack one cycle after the strobe rises
        poke(4, 32'hDEADBEEF);
        run(6'h23, 32'h0000_0010, 32'd0, 1, 0);
        chk("t1_data", last_data, 32'hDEADBEEF);
        chk("t1_err", {30'd0, last_err}, 32'd0);
        chk("t1_latency", 32'(last_resp_cyc - last_acc), 32'd3);

        // lb / lbu of the top byte
        poke(4, 32'h80FF7F01);
        run(6'h20, 32'h0000_0013, 32'd0, 0, 0);
        chk("t2_lb", last_data, 32'hFFFFFF80);
        chk("t2_lb_latency", 32'(last_resp_cyc - last_acc), 32'd2);
        run(6'h24, 32'h0000_0013, 32'd0, 0, 0);
        chk("t2_lbu", last_data, 32'h00000080);
        run(6'h21, 32'h0000_0012, 32'd0, 2, 0);
        chk("t2_lh", last_data, 32'hFFFF80FF);

        // sb into lane 1
        poke(8, 32'h11223344);
        run(6'h28, 32'h0000_0021, 32'h0000_00AA, 0, 0);
        chk("t3_mem", mem[8], 32'h1122AA44);
        chk("t3_latency", 32'(last_resp_cyc - last_acc), 32'd3);
        chk("t3_rd_wr", 32'(last_n_rd * 16 + last_n_wr), 32'h11);

        // accept-time errors
        run(6'h21, 32'h0000_0003, 32'd0, 0, 0);
        chk("t4_mis_err", {30'd0, last_err}, 32'd1);
        chk("t4_mis_latency", 32'(last_resp_cyc - last_acc), 32'd1);
        chk("t4_mis_nord", 32'(last_n_rd), 32'd0);
        run(6'h3F, 32'h0000_0000, 32'd0, 0, 0);
        chk("t4_ill_err", {30'd0, last_err}, 32'd3);
        run(6'h2B, 32'h0000_0002, 32'd0, 0, 0);
        chk("t4_sw_mis_err", {30'd0, last_err}, 32'd1);

        // write timeout, then ack landing on the last allowed cycle
        run(6'h2B, 32'h0000_0040, 32'h12345678, 0, NEVER);
        chk("t5_err", {30'd0, last_err}, 32'd2);
        chk("t5_wr_cycles", 32'(last_n_wr), 32'd16);
        poke(5, 32'h5555AAAA);
        run(6'h23, 32'h0000_0014, 32'd0, TO - 1, 0);
        chk("t5_ack_wins_err", {30'd0, last_err}, 32'd0);
        chk("t5_ack_wins_data", last_data, 32'h5555AAAA);
        run(6'h29, 32'h0000_0016, 32'h0000_BEEF, TO, 0);
        chk("t5_rd_tmo_err", {30'd0, last_err}, 32'd2);
        chk("t5_rd_tmo_nowr", 32'(last_n_wr), 32'd0);
        chk("t5_rd_tmo_mem", mem[5], 32'h5555AAAA);

        // reset while the write strobe is up
        issue(6'h2B, 32'h0000_0080, 32'hCAFEF00D, 0, NEVER);
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_in_wr", {31'd0, mem_wr}, 32'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("t6_mem_wr_drop", {31'd0, mem_wr}, 32'd0);
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_resp_valid", {31'd0, resp_valid}, 32'd0);
        n_rd_cnt = 0; n_wr_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        poke(20, 32'h0BADF00D);
        run(6'h23, 32'h0000_0050, 32'd0, 0, 0);
        chk("t6_after_data", last_data, 32'h0BADF00D);
        chk("t6_after_err", {30'd0, last_err}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (op == 6'h21 || op == 6'h25 || op == 6'h29) a[0] = 1'b0;
                if (op == 6'h23 || op == 6'h2B) a[1:0] = 2'b00;
            end
            rdd = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
            wrd = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
            run(op, a, $urandom, rdd, wrd);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
